skew_addr_gen: RTL and testbench

Parametrised frame-level deskew address generator, successor to the single-point skew accumulator.
- Walks a width x height pixel raster and emits one fixed-point source address per pixel: addr = offset + y*incr + (x << FRAC_W).
- incr is a signed per-line skew.
- Output is registered and uses a valid/ready stream.
- Sits between the deskew control registers and the line-buffer read port.

---
 rtl/skew_pkg.sv | 16 +
 rtl/skew_addr_gen_if.sv | 25 ++
 rtl/skew_addr_calc.sv | 38 +++
 rtl/skew_addr_gen.sv | 142 ++++++++++++++
 tb/tb_skew_addr_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/skew_pkg.sv
// Shared definitions for the skew address generator family: FSM encoding and
// default datapath widths.
package skew_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ACC_W_DEF  = 24;
    localparam int FRAC_W_DEF = 9;
    localparam int X_W_DEF    = 8;
    localparam int Y_W_DEF    = 12;

endpackage

// File: rtl/skew_addr_gen_if.sv
// Address beat stream from the deskew generator to the line-buffer read port.
interface skew_addr_gen_if
    import skew_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
);
    logic                    addr_valid;
    logic                    addr_ready;
    logic [ACC_W-FRAC_W-1:0] addr_int;
    logic [FRAC_W-1:0]       addr_frac;
    logic                    addr_oob;
    logic                    last_x;
    logic                    last_y;

    modport master (
        output addr_valid, addr_int, addr_frac, addr_oob, last_x, last_y,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, addr_int, addr_frac, addr_oob, last_x, last_y,
        output addr_ready
    );
endinterface

// File: rtl/skew_addr_calc.sv
// Combinational offset + acc + (x << FRAC_W) with out-of-range detection and
// clamp/wrap selection; shared by single- and multi-channel generators.
module skew_addr_calc
    import skew_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int X_W    = X_W_DEF
) (
    input  logic [ACC_W-1:0] offset_i,
    input  logic [ACC_W-1:0] acc_i,
    input  logic [X_W-1:0]   x_i,
    input  logic             clamp_mode_i,
    output logic [ACC_W-1:0] addr_o,
    output logic             oob_o
);
    localparam int SUM_W = ACC_W + 2;

    logic [ACC_W-1:0]        x_shift;
    logic signed [SUM_W-1:0] sum;

    assign x_shift = ACC_W'(x_i) << FRAC_W;

    // Two guard bits: offset and x are unsigned, only acc carries a sign.
    assign sum = $signed({2'b00, offset_i})
               + $signed({{2{acc_i[ACC_W-1]}}, acc_i})
               + $signed({2'b00, x_shift});

    // NOTE: every output gets a default at the top of always_comb so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        addr_o = sum[ACC_W-1:0];
        oob_o  = sum[SUM_W-1] | sum[ACC_W];
        if (oob_o && clamp_mode_i) begin
            addr_o = sum[SUM_W-1] ? '0 : '1;
        end
    end
endmodule

// File: rtl/skew_addr_gen.sv
// Frame deskew address generator: walks a width x height raster and streams
// one registered fixed-point source address per pixel.
module skew_addr_gen
    import skew_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             clamp_mode,
    input  logic [X_W:0]     width,
    input  logic [Y_W:0]     height,
    input  logic [ACC_W-1:0] incr,
    input  logic [ACC_W-1:0] offset,
    skew_addr_gen_if.master  addr_if,
    output logic             busy,
    output logic             done
);
    localparam logic [X_W:0]   W_ONE = 1;
    localparam logic [Y_W:0]   H_ONE = 1;
    localparam logic [X_W-1:0] X_ONE = 1;
    localparam logic [Y_W-1:0] Y_ONE = 1;

    state_e           state_q;
    logic [X_W:0]     width_q;
    logic [Y_W:0]     height_q;
    logic [ACC_W-1:0] incr_q, offset_q, acc_q;
    logic             clamp_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic             fin_q;
    logic             valid_q;
    logic [ACC_W-1:0] addr_q;
    logic             oob_q, last_x_q, last_y_q;

    logic [ACC_W-1:0] addr_d;
    logic             oob_d, last_x_d, last_y_d;
    logic             load;

    skew_addr_calc #(
        .ACC_W (ACC_W),
        .FRAC_W(FRAC_W),
        .X_W   (X_W)
    ) u_calc (
        .offset_i    (offset_q),
        .acc_i       (acc_q),
        .x_i         (x_q),
        .clamp_mode_i(clamp_q),
        .addr_o      (addr_d),
        .oob_o       (oob_d)
    );

    assign last_x_d = ({1'b0, x_q} == (width_q - W_ONE));
    assign last_y_d = ({1'b0, y_q} == (height_q - H_ONE));
    // fin_q stops loading once the final beat sits in the output register.
    assign load     = (state_q == RUN) && !fin_q && (!valid_q || addr_if.addr_ready);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            width_q  <= '0;
            height_q <= '0;
            incr_q   <= '0;
            offset_q <= '0;
            clamp_q  <= 1'b0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            fin_q    <= 1'b0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            oob_q    <= 1'b0;
            last_x_q <= 1'b0;
            last_y_q <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fin_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        width_q  <= width;
                        height_q <= height;
                        incr_q   <= incr;
                        offset_q <= offset;
                        clamp_q  <= clamp_mode;
                        acc_q    <= '0;
                        x_q      <= '0;
                        y_q      <= '0;
                        fin_q    <= 1'b0;
                        state_q  <= (width == '0 || height == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        valid_q  <= 1'b1;
                        addr_q   <= addr_d;
                        oob_q    <= oob_d;
                        last_x_q <= last_x_d;
                        last_y_q <= last_y_d;
                        if (last_x_d) begin
                            x_q   <= '0;
                            y_q   <= y_q + Y_ONE;
                            acc_q <= acc_q + incr_q;
                            fin_q <= last_y_d;
                        end else begin
                            x_q <= x_q + X_ONE;
                        end
                    end else if (valid_q && addr_if.addr_ready) begin
                        valid_q <= 1'b0;
                        if (fin_q) state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    fin_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr_if.addr_valid = valid_q;
    assign addr_if.addr_int   = addr_q[ACC_W-1:FRAC_W];
    assign addr_if.addr_frac  = addr_q[FRAC_W-1:0];
    assign addr_if.addr_oob   = oob_q;
    assign addr_if.last_x     = last_x_q;
    assign addr_if.last_y     = last_y_q;
    assign busy               = (state_q != IDLE);
    assign done               = (state_q == DONE);
endmodule

// File: tb/tb_skew_addr_gen.sv
// Directed bench for skew_addr_gen: table of frames with expected beats, plus
// hand-written backpressure, abort and mid-frame reset sequences.
module tb_skew_addr_gen;
    import skew_pkg::*;

    typedef struct {
        logic [8:0]  width;
        logic [12:0] height;
        logic [23:0] incr;
        logic [23:0] offset;
        logic        clamp;
        int          first;
        int          n;
    } frame_t;

    typedef struct {
        logic [23:0] addr;
        logic        oob;
        logic        lx;
        logic        ly;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        clamp_mode;
    logic [8:0]  width;
    logic [12:0] height;
    logic [23:0] incr;
    logic [23:0] offset;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    frame_t frames[7];
    beat_t  beats[16];

    skew_addr_gen_if #(.ACC_W(24), .FRAC_W(9)) aif ();

    skew_addr_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .clamp_mode(clamp_mode),
        .width     (width),
        .height    (height),
        .incr      (incr),
        .offset    (offset),
        .addr_if   (aif),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] cur_addr();
        return {aif.addr_int, aif.addr_frac};
    endfunction

    task automatic set_cfg(input int f);
        width      = frames[f].width;
        height     = frames[f].height;
        incr       = frames[f].incr;
        offset     = frames[f].offset;
        clamp_mode = frames[f].clamp;
    endtask

    task automatic check_beat(input string name, input int b);
        check({name, "_valid"}, aif.addr_valid, 1'b1);
        check({name, "_addr"}, cur_addr(), beats[b].addr);
        check({name, "_oob"}, aif.addr_oob, beats[b].oob);
        check({name, "_lx"}, aif.last_x, beats[b].lx);
        check({name, "_ly"}, aif.last_y, beats[b].ly);
    endtask

    // Called at a negedge; returns at a negedge. addr_ready is low for cycles
    // [st, st+sl) counted from the first negedge after the start edge.
    task automatic run_frame(input int f, input int st, input int sl);
        int  k        = 0;
        int  done_cyc = -1;
        bit  fin      = 1'b0;
        int  n        = frames[f].n;
        set_cfg(f);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            aif.addr_ready = !(cyc >= st && cyc < st + sl);
            if (cyc == 0) begin
                check($sformatf("f%0d_busy_after_start", f), busy, 1'b1);
                if (n > 0) check($sformatf("f%0d_no_beat_yet", f), aif.addr_valid, 1'b0);
            end
            if (done_cyc >= 0) begin
                check($sformatf("f%0d_done_one_cycle", f), done, 1'b0);
                check($sformatf("f%0d_idle_after_done", f), busy, 1'b0);
                fin = 1'b1;
            end else if (done) begin
                done_cyc = cyc;
                check($sformatf("f%0d_valid_at_done", f), aif.addr_valid, 1'b0);
            end
            if (aif.addr_valid) begin
                if (k < n) check_beat($sformatf("f%0d_b%0d", f, k), frames[f].first + k);
                else check($sformatf("f%0d_extra_beat", f), k + 1, n);
                if (aif.addr_ready) k++;
            end
            @(negedge clk);
        end
        aif.addr_ready = 1'b1;
        check($sformatf("f%0d_finished", f), fin, 1'b1);
        check($sformatf("f%0d_beat_count", f), k, n);
        check($sformatf("f%0d_done_cycle", f), done_cyc, (n == 0) ? 0 : n + 1 + sl);
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {aif.addr_valid, aif.addr_int, aif.addr_frac, aif.addr_oob,
                     aif.last_x, aif.last_y, busy, done}, 64'd0);
    endtask

    initial begin
        // Frame table: width, height, incr, offset, clamp, first beat, beat count
        frames[0] = '{9'd4, 13'd2, 24'h000100, 24'h001000, 1'b1, 0, 8};
        frames[1] = '{9'd1, 13'd2, 24'hFFFE00, 24'h000000, 1'b1, 8, 2};
        frames[2] = '{9'd1, 13'd2, 24'hFFFE00, 24'h000000, 1'b0, 10, 2};
        frames[3] = '{9'd2, 13'd1, 24'h000000, 24'hFFFE00, 1'b1, 12, 2};
        frames[4] = '{9'd2, 13'd1, 24'h000000, 24'hFFFE00, 1'b0, 14, 2};
        frames[5] = '{9'd0, 13'd5, 24'h000100, 24'h001000, 1'b1, 0, 0};
        frames[6] = '{9'd4, 13'd0, 24'h000100, 24'h001000, 1'b1, 0, 0};

        // Expected beats: addr, oob, last_x, last_y
        beats[0]  = '{24'h001000, 1'b0, 1'b0, 1'b0};
        beats[1]  = '{24'h001200, 1'b0, 1'b0, 1'b0};
        beats[2]  = '{24'h001400, 1'b0, 1'b0, 1'b0};
        beats[3]  = '{24'h001600, 1'b0, 1'b1, 1'b0};
        beats[4]  = '{24'h001100, 1'b0, 1'b0, 1'b1};
        beats[5]  = '{24'h001300, 1'b0, 1'b0, 1'b1};
        beats[6]  = '{24'h001500, 1'b0, 1'b0, 1'b1};
        beats[7]  = '{24'h001700, 1'b0, 1'b1, 1'b1};
        beats[8]  = '{24'h000000, 1'b0, 1'b1, 1'b0};
        beats[9]  = '{24'h000000, 1'b1, 1'b1, 1'b1};
        beats[10] = '{24'h000000, 1'b0, 1'b1, 1'b0};
        beats[11] = '{24'hFFFE00, 1'b1, 1'b1, 1'b1};
        beats[12] = '{24'hFFFE00, 1'b0, 1'b0, 1'b1};
        beats[13] = '{24'hFFFFFF, 1'b1, 1'b1, 1'b1};
        beats[14] = '{24'hFFFE00, 1'b0, 1'b0, 1'b1};
        beats[15] = '{24'h000000, 1'b1, 1'b1, 1'b1};

        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        aif.addr_ready = 1'b1;
        set_cfg(0);
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");

        for (int f = 0; f < 7; f++) run_frame(f, 0, 0);

        // Backpressure on beat 2 for three cycles.
        run_frame(0, 2, 3);

        // Second start while busy, then abort while beat 3 is valid.
        set_cfg(0);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        offset = 24'h005000;
        width  = 9'd2;
        @(negedge clk);
        start = 1'b0;
        set_cfg(0);
        check_beat("abort_b0", 0);
        @(negedge clk);
        check_beat("abort_b1", 1);
        @(negedge clk);
        check_beat("abort_b2", 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", aif.addr_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_no_done", done, 1'b0);
        @(negedge clk);
        check("abort_no_done_later", done, 1'b0);
        check("abort_stays_idle", {aif.addr_valid, busy}, 2'b00);

        // abort wins over start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_over_start", busy, 1'b0);
        @(negedge clk);
        check("abort_over_start_valid", aif.addr_valid, 1'b0);
        run_frame(0, 0, 0);

        // Asynchronous reset while beat 5 is valid.
        set_cfg(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check_beat("rst_b4", 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_outputs($sformatf("rst_release_idle%0d", i));
        end
        run_frame(1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
